dice_cgra_tid_tracker: RTL
==========================

// Module: dice_cgra_tid_tracker
// PURPOSE
// Multi-lane, runtime-latency TID tracking pipe for the DICE CGRA subsystem. Accepts up to NUM_LANES TIDs
// per beat from the dispatcher, delays them exactly cfg_latency cycles to line up with CGRA compute, and
// presents them as the RF/PRF writeback TID. Adds ready/valid backpressure, safe latency reconfiguration
// and optional same-TID hazard stalling.
// PARAMETERS
// NUM_TID      512                     total thread IDs per CTA
// TID_WIDTH    $clog2(NUM_TID)         TID width
// NUM_LANES    1                       TIDs accepted/retired per beat
// MAX_LATENCY  32                      pipe depth; legal cfg_latency 1..MAX_LATENCY
// LAT_WIDTH    $clog2(MAX_LATENCY+1)   latency / counter width
// PORTS
// clk            in   1                    clock
// rst_n          in   1                    async active-low reset
// clr            in   1                    sync flush
// cfg_latency    in   LAT_WIDTH            requested compute latency
// in_valid       in   1                    dispatcher beat valid
// in_ready       out  1                    beat accepted when in_valid&in_ready
// in_lane_mask   in   NUM_LANES            per-lane TID valid
// in_tid         in   NUM_LANES*TID_WIDTH  lane i at [i*TID_WIDTH +: TID_WIDTH]
// out_valid      out  1                    retiring beat valid; no ready, cannot stall
// out_lane_mask  out  NUM_LANES            retiring lane mask
// out_tid        out  NUM_LANES*TID_WIDTH  retiring TIDs
// inflight_cnt   out  LAT_WIDTH            beats currently in pipe
// done           out  1                    pipe empty
// err_dup        out  1                    sticky: duplicate TID within an accepted beat
// BEHAVIOUR
// - One clock; asynchronous active-low reset. Reset: out_valid=0, out_lane_mask=0, out_tid=0,
//   inflight_cnt=0, done=1, err_dup=0, all stage valids 0, lat_q=1.
// - Stages 0..MAX_LATENCY-1 each hold {valid, mask, tids}. All stages shift toward 0 every cycle.
//   Stage 0 drives out_* registered. An accepted beat enters stage lat_q-1.
// - Result: a beat accepted in cycle t has out_valid=1 in cycle t+lat_q. Back-to-back beats retire back-to-back.
// - lat_q: latched copy of cfg_latency. It loads only when the pipe is empty (done=1) or on clr.
//   cfg_latency=0 or >MAX_LATENCY clamps to 1 / MAX_LATENCY.
// - in_ready = !clr & !lat_block & !hazard.
//   lat_block = (clamp(cfg_latency)!=lat_q) & !done. This prevents reordering when latency changes mid-flight.
//   After drain, lat_q updates. in_ready can rise in that same cycle only if lat_block clears.
// - inflight_cnt: +1 on accept, -1 when a stage-0 valid beat leaves. Simultaneous accept and retire: unchanged.
//   done = (inflight_cnt==0), registered.
// - in_valid with in_lane_mask=0 is still a beat: it occupies a slot and retires with mask 0 and out_valid=1.
// - Two enabled lanes of one accepted beat carrying the same TID set err_dup (sticky until reset/clr).
//   The beat is still accepted.
// - clr: the next state clears every stage valid, counter and scoreboard. lat_q reloads from cfg_latency.
//   out_valid=0 and done=1 the cycle after. in_ready=0 during the clr cycle.
// CONFIGURATION
// - DICE_TID_HAZARD_CHECK_EN defined:
//   - An NUM_TID-bit scoreboard sets bits for enabled lanes on accept and clears them on retire
//     (retire-clear is visible the following cycle).
//   - hazard=1 if any enabled in_tid bit is set. A TID retiring in the current cycle still counts as a hazard,
//     which guarantees the RF write precedes the re-read.
// - Undefined: no scoreboard; hazard=0.
// STRUCTURE
// - dice_cgra_pkg: tid_t, lat_t, tid_stage_t struct {valid, mask, tids}, function clamp_latency().
// - Sub-module dice_tid_scoreboard: set/clear vectors, lookup of NUM_LANES TIDs.
//   Instantiated only under DICE_TID_HAZARD_CHECK_EN.
// TESTING
// - Basic latency: lat=3, accept tid 5 at cycle 10 -> out_valid with out_tid=5 at cycle 13; done=0 for
//   cycles 11-13 and 1 at cycle 14.
// - Streaming: lat=1, tids 0..7 on consecutive cycles -> out 0..7 consecutive; inflight_cnt holds 1.
// - Latency change mid-flight: lat 4->2 while 2 beats are in flight -> in_ready=0 until drain,
//   then new beat retires 2 cycles after accept.
// - Hazard (EN): tid 9 in flight at lat=6, offer tid 9 -> stalled until the cycle after 9 retires;
//   offer tid 10 -> accepted immediately.
// - clr mid-operation: 3 beats in flight, clr pulse -> next cycle out_valid=0, inflight_cnt=0, done=1;
//   no stale TID ever retires.
// - Multi-lane: NUM_LANES=4, mask 4'b1010, tids {7,3,7,1} -> retires same mask/tids after lat_q;
//   duplicate beat {2,2,x,x} mask 0011 sets err_dup.

Source files
------------

// File: rtl/dice_cgra_pkg.sv
// Shared types and helpers for the DICE CGRA TID tracking pipe.
// Defaults describe the single-lane, 512-TID, 32-deep configuration.
package dice_cgra_pkg;

  localparam int DICE_NUM_TID     = 512;
  localparam int DICE_TID_WIDTH   = $clog2(DICE_NUM_TID);
  localparam int DICE_NUM_LANES   = 1;
  localparam int DICE_MAX_LATENCY = 32;
  localparam int DICE_LAT_WIDTH   = $clog2(DICE_MAX_LATENCY + 1);

  typedef logic [DICE_TID_WIDTH-1:0] tid_t;
  typedef logic [DICE_LAT_WIDTH-1:0] lat_t;

  typedef struct packed {
    logic                                     valid;
    logic [DICE_NUM_LANES-1:0]                mask;
    logic [DICE_NUM_LANES*DICE_TID_WIDTH-1:0] tids;
  } tid_stage_t;

  // Out-of-range latency requests snap to the nearest legal depth.
  function automatic int clamp_latency(input int cfg, input int max_lat);
    if (cfg < 1) return 1;
    if (cfg > max_lat) return max_lat;
    return cfg;
  endfunction

endpackage

// File: rtl/dice_tid_scoreboard.sv
// One bit per TID marking it as in flight; set on accept, cleared on retire.
// Lookup reads the registered bits, so a TID retiring this cycle still hits.
module dice_tid_scoreboard
  import dice_cgra_pkg::*;
#(
  parameter int NUM_TID   = DICE_NUM_TID,
  parameter int TID_WIDTH = $clog2(NUM_TID),
  parameter int NUM_LANES = DICE_NUM_LANES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           set_en,
  input  logic [NUM_LANES-1:0]           set_mask,
  input  logic [NUM_LANES*TID_WIDTH-1:0] set_tids,
  input  logic                           clr_en,
  input  logic [NUM_LANES-1:0]           clr_mask,
  input  logic [NUM_LANES*TID_WIDTH-1:0] clr_tids,
  input  logic [NUM_LANES-1:0]           look_mask,
  input  logic [NUM_LANES*TID_WIDTH-1:0] look_tids,
  output logic                           hit
);

  logic [NUM_TID-1:0] sb_q;
  logic [NUM_TID-1:0] sb_d;

  always_comb begin
    sb_d = sb_q;
    if (clr_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (clr_mask[i]) sb_d[clr_tids[i*TID_WIDTH +: TID_WIDTH]] = 1'b0;
      end
    end
    if (set_en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (set_mask[i]) sb_d[set_tids[i*TID_WIDTH +: TID_WIDTH]] = 1'b1;
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (look_mask[i] && sb_q[look_tids[i*TID_WIDTH +: TID_WIDTH]]) hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else if (clr) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/dice_cgra_tid_tracker.sv
// Runtime-latency TID delay pipe: beats enter stage lat-1 and retire from stage 0.
// Optional same-TID hazard stalling is built when DICE_TID_HAZARD_CHECK_EN is defined.
module dice_cgra_tid_tracker
  import dice_cgra_pkg::*;
#(
  parameter int NUM_TID     = DICE_NUM_TID,
  parameter int TID_WIDTH   = $clog2(NUM_TID),
  parameter int NUM_LANES   = DICE_NUM_LANES,
  parameter int MAX_LATENCY = DICE_MAX_LATENCY,
  parameter int LAT_WIDTH   = $clog2(MAX_LATENCY + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic [LAT_WIDTH-1:0]           cfg_latency,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_LANES-1:0]           in_lane_mask,
  input  logic [NUM_LANES*TID_WIDTH-1:0] in_tid,
  output logic                           out_valid,
  output logic [NUM_LANES-1:0]           out_lane_mask,
  output logic [NUM_LANES*TID_WIDTH-1:0] out_tid,
  output logic [LAT_WIDTH-1:0]           inflight_cnt,
  output logic                           done,
  output logic                           err_dup
);

  typedef struct packed {
    logic                           valid;
    logic [NUM_LANES-1:0]           mask;
    logic [NUM_LANES*TID_WIDTH-1:0] tids;
  } stage_t;

  stage_t               stg_q [MAX_LATENCY];
  stage_t               stg_d [MAX_LATENCY];
  logic [LAT_WIDTH-1:0] lat_q;
  logic [LAT_WIDTH-1:0] lat_cfg;
  logic [LAT_WIDTH-1:0] lat_eff;
  logic [LAT_WIDTH-1:0] cnt_q;
  logic [LAT_WIDTH-1:0] cnt_d;
  logic                 done_q;
  logic                 err_dup_q;
  logic                 dup;
  logic                 hazard;
  logic                 lat_block;
  logic                 accept;
  logic                 retire;

  // Handshake: a beat transfers on any cycle where in_valid && in_ready; the
  // output side has no ready and retires unconditionally from stage 0.
  assign lat_cfg   = LAT_WIDTH'(clamp_latency(int'(cfg_latency), MAX_LATENCY));
  assign lat_block = (lat_cfg != lat_q) & ~done_q;
  assign in_ready  = ~clr & ~lat_block & ~hazard;
  assign accept    = in_valid & in_ready;
  assign retire    = stg_q[0].valid;
  // lat_q reloads while empty, so an accept in that cycle already uses the new depth.
  assign lat_eff   = done_q ? lat_cfg : lat_q;

  always_comb begin
    for (int i = 0; i < MAX_LATENCY - 1; i++) begin
      stg_d[i] = stg_q[i+1];
    end
    stg_d[MAX_LATENCY-1] = '0;
    for (int i = 0; i < MAX_LATENCY; i++) begin
      if (accept && (LAT_WIDTH'(i + 1) == lat_eff)) begin
        stg_d[i].valid = 1'b1;
        stg_d[i].mask  = in_lane_mask;
        stg_d[i].tids  = in_tid;
      end
    end
    if (clr) begin
      for (int i = 0; i < MAX_LATENCY; i++) begin
        stg_d[i] = '0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !retire) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && retire) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (clr) cnt_d = '0;
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (in_lane_mask[i] && in_lane_mask[j] &&
            (in_tid[i*TID_WIDTH +: TID_WIDTH] == in_tid[j*TID_WIDTH +: TID_WIDTH])) begin
          dup = 1'b1;
        end
      end
    end
  end

`ifdef DICE_TID_HAZARD_CHECK_EN
  dice_tid_scoreboard #(
    .NUM_TID   (NUM_TID),
    .TID_WIDTH (TID_WIDTH),
    .NUM_LANES (NUM_LANES)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .set_en    (accept),
    .set_mask  (in_lane_mask),
    .set_tids  (in_tid),
    .clr_en    (retire),
    .clr_mask  (stg_q[0].mask),
    .clr_tids  (stg_q[0].tids),
    .look_mask (in_lane_mask),
    .look_tids (in_tid),
    .hit       (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LATENCY; i++) begin
        stg_q[i] <= '0;
      end
      lat_q     <= LAT_WIDTH'(1);
      cnt_q     <= '0;
      done_q    <= 1'b1;
      err_dup_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LATENCY; i++) begin
        stg_q[i] <= stg_d[i];
      end
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == '0);
      if (clr || done_q) lat_q <= lat_cfg;
      if (clr) begin
        err_dup_q <= 1'b0;
      end else if (accept && dup) begin
        err_dup_q <= 1'b1;
      end
    end
  end

  assign out_valid     = stg_q[0].valid;
  assign out_lane_mask = stg_q[0].mask;
  assign out_tid       = stg_q[0].tids;
  assign inflight_cnt  = cnt_q;
  assign done          = done_q;
  assign err_dup       = err_dup_q;

endmodule
